// File: rtl/hit_arb_pkg.sv
// hit_arb_pkg: shared types and default constants for hit_write_arbiter.
//   lamp_state_t   : target-lamp FSM encoding (LIT, DARK)
//   DEF_ON_CYCLES  : default cycles the lamp stays lit without a hit
//   DEF_OFF_CYCLES : default cycles the lamp stays dark
//   DEF_STATUS_REG : default regfile index that receives injected hit counts
package hit_arb_pkg;

  typedef enum logic {
    LIT  = 1'b0,
    DARK = 1'b1
  } lamp_state_t;

  localparam int unsigned DEF_ON_CYCLES  = 32'd200000000;
  localparam int unsigned DEF_OFF_CYCLES = 32'd250000000;
  localparam int unsigned DEF_STATUS_REG = 32'd30;

endpackage

// File: rtl/lamp_timer.sv
// lamp_timer: target-lamp on/off FSM with its dwell timer.
//   clk    : system clock, all state on rising edge
//   reset  : asynchronous, active-high; returns to LIT with timer 0
//   hit    : one-cycle hit event (falling edge of the conditioned button)
//   lamp   : 1 while the FSM is LIT
//   scored : combinational, hit arriving while LIT; this is the hit that
//            counts and that moves the FSM to DARK at this edge
//   state  : FSM state, exposed for checkers
module lamp_timer
  import hit_arb_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
  parameter int unsigned OFF_CYCLES = DEF_OFF_CYCLES,
  parameter int unsigned TMR_W      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hit,
  output logic        lamp,
  output logic        scored,
  output lamp_state_t state
);

  localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_CYCLES - 1);

  logic [TMR_W-1:0] timer;

  // Hits in DARK are ignored entirely.
  assign scored = hit && (state == LIT);
  assign lamp   = (state == LIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LIT;
      timer <= '0;
    end else begin
      case (state)
        LIT: begin
          // A hit on the timeout cycle still scores: hit is tested first.
          if (hit || (timer == ON_LAST)) begin
            state <= DARK;
            timer <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        DARK: begin
          if (timer == OFF_LAST) begin
            state <= LIT;
            timer <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          state <= LIT;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hit_write_arbiter.sv
// hit_write_arbiter: owns the regfile write port between the processor and
// the hit-scoring logic. Runs the target lamp, counts hits against the lit
// lamp, and injects the pending count into STATUS_REG whenever the processor
// leaves the write port idle.
//   clk, reset           : clock; asynchronous active-high reset
//   btn                  : raw hit button, active-low
//   cpu_we/cpu_rd/cpu_data: processor regfile write request
//   rf_we/rf_rd/rf_data  : regfile write port (combinational mux)
//   lamp                 : target lamp, 1 = lit
//   pending              : hits counted but not yet injected
//   inject_ack           : an injection write is presented this cycle
//   dropped              : one-cycle pulse, a hit lost to saturation
// Build option: define HIT_SYNC_EN to pass btn through a 2-flop synchronizer
// before edge detection (hit lands two edges later than without it).
//
// Write port semantics: rf_we is the sole qualifier; there is no ready. The
// regfile accepts whatever is presented at the next rising edge. The
// processor always wins; an injection only fills cycles where cpu_we = 0, and
// the count it carries is consumed at that same edge.
module hit_write_arbiter
  import hit_arb_pkg::*;
#(
  parameter int unsigned STATUS_REG = DEF_STATUS_REG,
  parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
  parameter int unsigned OFF_CYCLES = DEF_OFF_CYCLES,
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned TMR_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn,
  input  logic             cpu_we,
  input  logic [4:0]       cpu_rd,
  input  logic [31:0]      cpu_data,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [31:0]      rf_data,
  output logic             lamp,
  output logic [CNT_W-1:0] pending,
  output logic             inject_ack,
  output logic             dropped
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic        btn_cond;
  logic        btn_prev;
  logic        hit;
  logic        scored;
  logic        inject;
  logic [CNT_W-1:0] pending_base;
  logic [CNT_W-1:0] pending_next;
  logic        dropped_next;
  lamp_state_t lamp_state;

  // Button conditioning. Sample flops reset to 1 (released) so that leaving
  // reset can never look like a falling edge.
`ifdef HIT_SYNC_EN
  logic btn_s1;
  logic btn_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1   <= 1'b1;
      btn_s2   <= 1'b1;
      btn_prev <= 1'b1;
    end else begin
      btn_s1   <= btn;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  assign btn_cond = btn_s2;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_prev <= 1'b1;
    end else begin
      btn_prev <= btn;
    end
  end

  assign btn_cond = btn;
`endif

  // Falling edge only, so a held button yields a single hit.
  assign hit = btn_prev & ~btn_cond;

  lamp_timer #(
    .ON_CYCLES  (ON_CYCLES),
    .OFF_CYCLES (OFF_CYCLES),
    .TMR_W      (TMR_W)
  ) u_lamp_timer (
    .clk    (clk),
    .reset  (reset),
    .hit    (hit),
    .lamp   (lamp),
    .scored (scored),
    .state  (lamp_state)
  );

  // Write-port arbitration: processor has absolute priority.
  assign inject     = !cpu_we && (pending != '0);
  assign inject_ack = inject;
  assign rf_we      = cpu_we | inject;
  assign rf_rd      = inject ? 5'(STATUS_REG) : cpu_rd;
  assign rf_data    = inject ? 32'(pending) : cpu_data;

  // An injection hands the whole count to software, so the base restarts at
  // zero; a hit in the same cycle therefore leaves exactly 1 behind.
  always_comb begin
    pending_base = inject ? '0 : pending;
    pending_next = pending_base;
    dropped_next = 1'b0;
    if (scored) begin
      if (pending_base == CNT_MAX) begin
        dropped_next = 1'b1;
      end else begin
        pending_next = pending_base + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      dropped <= 1'b0;
    end else begin
      pending <= pending_next;
      dropped <= dropped_next;
    end
  end

endmodule

// File: tb/tb_hit_write_arbiter.sv
module tb_hit_write_arbiter;

  localparam int ON    = 8;
  localparam int OFF   = 4;
  localparam int CNT_W = 3;
  localparam int MAXP  = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             btn;
  logic             cpu_we;
  logic [4:0]       cpu_rd;
  logic [31:0]      cpu_data;
  logic             rf_we;
  logic [4:0]       rf_rd;
  logic [31:0]      rf_data;
  logic             lamp;
  logic [CNT_W-1:0] pending;
  logic             inject_ack;
  logic             dropped;

  hit_write_arbiter #(
    .STATUS_REG (30),
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF),
    .CNT_W      (CNT_W),
    .TMR_W      (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .cpu_we     (cpu_we),
    .cpu_rd     (cpu_rd),
    .cpu_data   (cpu_data),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_data    (rf_data),
    .lamp       (lamp),
    .pending    (pending),
    .inject_ack (inject_ack),
    .dropped    (dropped)
  );

  int checks   = 0;
  int failures = 0;
  int drops_seen = 0;

  // scoreboard of injected values
  logic [31:0] exp_q[$];

  // reference model state
  bit m_lit;
  int m_timer;
  int m_pending;
  bit m_prev;
  bit m_dropped;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lit     = 1'b1;
    m_timer   = 0;
    m_pending = 0;
    m_prev    = 1'b1;
    m_dropped = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs held this cycle.
  task automatic model_edge();
    bit hit_e;
    bit scored_e;
    bit inj_e;
    int base;
    hit_e    = m_prev && !btn;
    scored_e = m_lit && hit_e;
    inj_e    = !cpu_we && (m_pending != 0);
    base     = inj_e ? 0 : m_pending;
    m_dropped = 1'b0;
    if (scored_e) begin
      if (base == MAXP) m_dropped = 1'b1;
      else base = base + 1;
    end
    m_pending = base;
    if (m_lit) begin
      if (scored_e || m_timer == ON - 1) begin
        m_lit = 1'b0;
        m_timer = 0;
      end else m_timer++;
    end else begin
      if (m_timer == OFF - 1) begin
        m_lit = 1'b1;
        m_timer = 0;
      end else m_timer++;
    end
    m_prev = btn;
  endtask

  // ---------------- driver tasks ----------------
  // Drive inputs at the falling edge, then compare all outputs against the model.
  task automatic drive_set(input bit b, input bit we, input logic [4:0] rd, input logic [31:0] d);
    bit inj;
    logic [31:0] e;
    @(negedge clk);
    btn      = b;
    cpu_we   = we;
    cpu_rd   = rd;
    cpu_data = d;
    inj = !we && (m_pending != 0);
    if (inj) exp_q.push_back(32'(m_pending));
    #1;
    check("lamp", 32'(lamp), 32'(m_lit));
    check("pending", 32'(pending), 32'(m_pending));
    check("dropped", 32'(dropped), 32'(m_dropped));
    check("rf_we", 32'(rf_we), 32'(we | inj));
    check("rf_rd", 32'(rf_rd), inj ? 32'd30 : 32'(rd));
    check("rf_data", rf_data, inj ? 32'(m_pending) : d);
    check("inject_ack", 32'(inject_ack), 32'(inj));
    if (dropped === 1'b1) drops_seen++;
    if (inject_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_inject actual=%0h required=none", rf_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_inject_value", rf_data, e);
      end
    end
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_edge();
  endtask

  task automatic cycle(input bit b, input bit we);
    drive_set(b, we, 5'($urandom_range(0, 31)), $urandom);
    finish_cycle();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    btn    = 1'b1;
    cpu_we = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_lamp", 32'(lamp), 32'd1);
    check("rst_pending", 32'(pending), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    bit          b;
    bit          we;
    logic [4:0]  rd;
    logic [31:0] d;
    bit          e_lamp;
    logic [2:0]  e_pend;
    bit          e_rf_we;
    logic [4:0]  e_rf_rd;
    logic [31:0] e_rf_data;
  } vec_t;

  vec_t vt[9];

  initial begin
    // single hit in cycle 3 of LIT, injected next cycle, then a cpu write
    vt[0] = '{1'b1, 1'b0, 5'd3, 32'h11,   1'b1, 3'd0, 1'b0, 5'd3,  32'h11};
    vt[1] = '{1'b1, 1'b0, 5'd4, 32'h22,   1'b1, 3'd0, 1'b0, 5'd4,  32'h22};
    vt[2] = '{1'b1, 1'b0, 5'd5, 32'h33,   1'b1, 3'd0, 1'b0, 5'd5,  32'h33};
    vt[3] = '{1'b0, 1'b0, 5'd6, 32'h44,   1'b1, 3'd0, 1'b0, 5'd6,  32'h44};
    vt[4] = '{1'b0, 1'b0, 5'd7, 32'h55,   1'b0, 3'd1, 1'b1, 5'd30, 32'h1};
    vt[5] = '{1'b0, 1'b1, 5'd9, 32'hABCD, 1'b0, 3'd0, 1'b1, 5'd9,  32'hABCD};
    vt[6] = '{1'b1, 1'b0, 5'd2, 32'h66,   1'b0, 3'd0, 1'b0, 5'd2,  32'h66};
    vt[7] = '{1'b1, 1'b0, 5'd2, 32'h77,   1'b0, 3'd0, 1'b0, 5'd2,  32'h77};
    vt[8] = '{1'b1, 1'b0, 5'd1, 32'h88,   1'b1, 3'd0, 1'b0, 5'd1,  32'h88};

    // reset state, with cpu passthrough during reset
    reset    = 1'b1;
    btn      = 1'b1;
    cpu_we   = 1'b1;
    cpu_rd   = 5'd7;
    cpu_data = 32'hDEAD_BEEF;
    #1;
    check("reset_lamp", 32'(lamp), 32'd1);
    check("reset_pending", 32'(pending), 32'd0);
    check("reset_dropped", 32'(dropped), 32'd0);
    check("reset_rf_we", 32'(rf_we), 32'd1);
    check("reset_rf_rd", 32'(rf_rd), 32'd7);
    check("reset_rf_data", rf_data, 32'hDEAD_BEEF);
    check("reset_inject_ack", 32'(inject_ack), 32'd0);
    cpu_we = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();

    // idle: lamp 8 on, 4 off, repeating; no writes
    for (int i = 0; i < 36; i++) begin
      drive_set(1'b1, 1'b0, 5'd0, 32'd0);
      check("idle_lamp", 32'(lamp), ((i % 12) < 8) ? 32'd1 : 32'd0);
      check("idle_rf_we", 32'(rf_we), 32'd0);
      finish_cycle();
    end

    // table-driven single hit sequence
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      drive_set(vt[i].b, vt[i].we, vt[i].rd, vt[i].d);
      check($sformatf("vec%0d_lamp", i), 32'(lamp), 32'(vt[i].e_lamp));
      check($sformatf("vec%0d_pending", i), 32'(pending), 32'(vt[i].e_pend));
      check($sformatf("vec%0d_rf_we", i), 32'(rf_we), 32'(vt[i].e_rf_we));
      check($sformatf("vec%0d_rf_rd", i), 32'(rf_rd), 32'(vt[i].e_rf_rd));
      check($sformatf("vec%0d_rf_data", i), rf_data, vt[i].e_rf_data);
      finish_cycle();
    end

    // hit while cpu_we held for 5 cycles
    apply_reset();
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive_set(1'b0, 1'b1, 5'd12, 32'h1234_0000 + 32'(i));
      check("hold_pending", 32'(pending), 32'd1);
      check("hold_rf_rd", 32'(rf_rd), 32'd12);
      check("hold_rf_data", rf_data, 32'h1234_0000 + 32'(i));
      finish_cycle();
    end
    drive_set(1'b0, 1'b0, 5'd3, 32'h5);
    check("hold_inj_we", 32'(rf_we), 32'd1);
    check("hold_inj_rd", 32'(rf_rd), 32'd30);
    check("hold_inj_data", rf_data, 32'd1);
    finish_cycle();
    drive_set(1'b1, 1'b0, 5'd3, 32'h5);
    check("hold_after_pending", 32'(pending), 32'd0);
    check("hold_after_we", 32'(rf_we), 32'd0);
    finish_cycle();

    // saturation: 9 hits while the processor owns the port
    apply_reset();
    drops_seen = 0;
    for (int h = 0; h < 9; h++) begin
      cycle(1'b0, 1'b1);
      for (int j = 0; j < 4; j++) cycle(1'b1, 1'b1);
    end
    check("sat_drop_pulses", 32'(drops_seen), 32'd2);
    drive_set(1'b1, 1'b1, 5'd4, 32'h9);
    check("sat_pending", 32'(pending), 32'd7);
    finish_cycle();
    drive_set(1'b1, 1'b0, 5'd4, 32'h9);
    check("sat_inj_we", 32'(rf_we), 32'd1);
    check("sat_inj_rd", 32'(rf_rd), 32'd30);
    check("sat_inj_data", rf_data, 32'd7);
    finish_cycle();

    // hit coincident with injection of 2
    apply_reset();
    cycle(1'b0, 1'b1);
    for (int j = 0; j < 4; j++) cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    for (int j = 0; j < 4; j++) cycle(1'b1, 1'b1);
    drive_set(1'b0, 1'b0, 5'd1, 32'h0);
    check("coinc_inj_we", 32'(rf_we), 32'd1);
    check("coinc_inj_data", rf_data, 32'd2);
    finish_cycle();
    drive_set(1'b1, 1'b1, 5'd1, 32'h0);
    check("coinc_after_pending", 32'(pending), 32'd1);
    finish_cycle();
    cycle(1'b1, 1'b0);

    // asynchronous reset while DARK with pending=3
    apply_reset();
    for (int h = 0; h < 3; h++) begin
      cycle(1'b0, 1'b1);
      if (h < 2) for (int j = 0; j < 4; j++) cycle(1'b1, 1'b1);
    end
    drive_set(1'b1, 1'b1, 5'd2, 32'h2);
    check("pre_rst_lamp", 32'(lamp), 32'd0);
    check("pre_rst_pending", 32'(pending), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_lamp", 32'(lamp), 32'd1);
    check("mid_rst_pending", 32'(pending), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      drive_set(1'b1, 1'b0, 5'd2, 32'h2);
      check("post_rst_no_inject", 32'(rf_we), 32'd0);
      finish_cycle();
    end
    cycle(1'b0, 1'b0);
    drive_set(1'b1, 1'b0, 5'd2, 32'h2);
    check("post_rst_inj_we", 32'(rf_we), 32'd1);
    check("post_rst_inj_data", rf_data, 32'd1);
    finish_cycle();

    // random traffic against the model
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
